// File: rtl/fifo_traffic_gen.sv
// fifo_traffic_gen: LFSR-driven stimulus master and self-checker for a synchronous FIFO.
// Drives write/read ports within the flags and scores wr_ack, data_out, overflow and underflow.
module fifo_traffic_gen #(
  parameter int FIFO_WIDTH = 16,
  parameter int NUM_TXN = 64,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic                  full,
  input  logic                  empty,
  input  logic                  wr_ack,
  input  logic                  overflow,
  input  logic                  underflow,
  input  logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           wr_count,
  output logic [15:0]           rd_count,
  output logic [15:0]           err_count
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  localparam logic [15:0] N = 16'(NUM_TXN);
  localparam logic [15:0] N_LAST = 16'(NUM_TXN - 1);
  state_t state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic phase_q, phase_d;
  logic [15:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, err_q, err_d;
  logic [15:0] tx_q, tx_d, rx_q, rx_d, rnd_q, rnd_d;
  logic wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d, done_q, done_d;
  logic run, wr_room, want_wr, want_rd;
  logic [FIFO_WIDTH-1:0] tx_w, rx_w;
  logic [2:0] n_err;
  logic [16:0] err_sum;
  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
  endfunction
  assign tx_w = FIFO_WIDTH'(tx_q);
  assign rx_w = FIFO_WIDTH'(rx_q);
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign wr_count = wr_cnt_q;
  assign rd_count = rd_cnt_q;
  assign err_count = err_q;
  always_comb begin
    run = state_q == RUN;
    wr_room = wr_cnt_q < N;
    want_wr = mode_q == 2'd2 ? rnd_q[0] : mode_q == 2'd0 ? ~phase_q : 1'b1;
    want_rd = mode_q == 2'd2 ? rnd_q[1] : mode_q == 2'd0 ? phase_q : 1'b1;
    wr_en = rst_n & run & want_wr & ~full & wr_room;
    rd_en = rst_n & run & want_rd & ~empty;
    data_in = busy ? tx_w : '0;
  end
  // Every response is scored one cycle after its issue; flags are scored whenever busy.
  always_comb begin
    n_err = 3'(wr_pend_q & ~wr_ack) + 3'(rd_pend_q & (data_out != rx_w))
          + 3'(busy & overflow) + 3'(busy & underflow);
    err_sum = {1'b0, err_q} + 17'(n_err);
    state_d = state_q;
    mode_d = mode_q;
    phase_d = phase_q;
    wr_cnt_d = wr_cnt_q + 16'(wr_en);
    rd_cnt_d = rd_cnt_q + 16'(rd_en);
    err_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    tx_d = wr_en ? lfsr_next(tx_q) : tx_q;
    rx_d = rd_pend_q ? lfsr_next(rx_q) : rx_q;
    rnd_d = run ? lfsr_next(rnd_q) : rnd_q;
    wr_pend_d = wr_en;
    rd_pend_d = rd_en;
    done_d = state_q == FLUSH;
    if (state_q == IDLE && start) begin
      state_d = RUN;
      mode_d = mode;
      phase_d = 1'b0;
      wr_cnt_d = '0;
      rd_cnt_d = '0;
      err_d = '0;
      tx_d = SEED;
      rx_d = SEED;
      rnd_d = ~SEED;
      wr_pend_d = 1'b0;
      rd_pend_d = 1'b0;
    end else if (run) begin
      // Fill/drain: switch to draining on full (or all words written), back to filling on empty.
      phase_d = phase_q ? ~(empty & wr_room) : (full | ~wr_room);
      state_d = rd_en && rd_cnt_q == N_LAST ? FLUSH : RUN;
    end else if (state_q == FLUSH) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q <= 2'd0;
      phase_q <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      err_q <= '0;
      tx_q <= SEED;
      rx_q <= SEED;
      rnd_q <= ~SEED;
      wr_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      phase_q <= phase_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      err_q <= err_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      rnd_q <= rnd_d;
      wr_pend_q <= wr_pend_d;
      rd_pend_q <= rd_pend_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_fifo_traffic_gen.sv
// tb_fifo_traffic_gen: depth-8 FIFO model opposite the generator, directed runs in every mode.
module tb_fifo_traffic_gen;
  localparam int N = 16;
  localparam logic [15:0] SEED = 16'hACE1;
  logic clk = 0, rst_n = 0, start = 0;
  logic [1:0] mode = 0;
  logic full, empty, wr_ack, overflow, underflow;
  logic [15:0] data_out, data_in, wr_count, rd_count, err_count;
  logic wr_en, rd_en, busy, done;
  int vec = 0, bad = 0;
  always #5 clk = ~clk;
  fifo_traffic_gen #(.FIFO_WIDTH(16), .NUM_TXN(N), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .full(full), .empty(empty),
    .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow), .data_out(data_out),
    .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in), .busy(busy), .done(done),
    .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count));
  function automatic logic [15:0] lfsr(input logic [15:0] x);
    return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
  endfunction
  // FIFO model with one-shot fault injection keyed to its push/pop counts.
  logic [15:0] mem [8];
  logic [3:0] cnt;
  logic [2:0] wp, rp;
  int pushes = 0, pops = 0, flip_at = 0, drop_at = 0, ov_at = 0;
  assign full = cnt == 4'd8;
  assign empty = cnt == 4'd0;
  always @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 0; wp <= 0; rp <= 0; wr_ack <= 0; overflow <= 0; underflow <= 0; data_out <= 0;
    end else begin
      wr_ack <= wr_en & !full & (pushes + 1 != drop_at);
      overflow <= (wr_en & full) | (wr_en & !full & (pushes + 1 == ov_at));
      underflow <= rd_en & empty;
      if (wr_en & !full) begin
        mem[wp] <= data_in; wp <= wp + 1; pushes <= pushes + 1;
      end
      if (rd_en & !empty) begin
        data_out <= mem[rp] ^ {15'b0, pops + 1 == flip_at}; rp <= rp + 1; pops <= pops + 1;
      end
      cnt <= cnt + 4'(wr_en & !full) - 4'(rd_en & !empty);
    end
  end
  logic [15:0] ex, rm;
  logic [1:0] mon_mode = 0;
  logic full_d = 0;
  int both = 0, flags = 0, dbad = 0, rbad = 0, fulls = 0;
  always @(posedge clk) begin
    if (rst_n && start && !busy) begin
      ex = SEED; rm = ~SEED; mon_mode = mode;
    end else if (rst_n && busy) begin
      if (wr_en & rd_en) both++;
      if (overflow | underflow) flags++;
      if (full & !full_d) fulls++;
      if (wr_en & !full) begin
        if (data_in !== ex) dbad++;
        ex = lfsr(ex);
      end
      if (mon_mode == 2 && (wr_en !== (rm[0] & !full & (wr_count < N)) ||
                            rd_en !== (rm[1] & !empty & (rd_count < N)))) rbad++;
      rm = lfsr(rm);
    end
    full_d = full;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [1:0] m, input int poke, output int cyc);
    cyc = 0;
    @(negedge clk); mode = m; start = 1;
    @(negedge clk); start = 0;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      start = (k == poke);
      if (done) begin
        cyc = k;
        break;
      end
    end
    start = 0;
  endtask
  int c, b0, f0, fl0, r0, nd;
  initial begin
    repeat (2) @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_en", rd_en, 0);
    rst_n = 1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data_in", data_in, 0);
    check("rst_counts", {wr_count, rd_count}, 0);
    check("rst_err", err_count, 0);
    b0 = both; f0 = fulls; fl0 = flags;
    run(0, 0, c);
    check("m0_cycles", c, 36);
    check("m0_wr", wr_count, N);
    check("m0_rd", rd_count, N);
    check("m0_err", err_count, 0);
    check("m0_busy", busy, 0);
    check("m0_fulls", fulls - f0, 2);
    check("m0_both", both - b0, 0);
    check("m0_flags", flags - fl0, 0);
    @(negedge clk);
    check("m0_done_pulse", done, 0);
    check("m0_hold", {wr_count, rd_count}, {16'(N), 16'(N)});
    b0 = both; fl0 = flags;
    run(1, 0, c);
    check("m1_cycles", c, 18);
    check("m1_both", both - b0, 15);
    check("m1_rd", rd_count, N);
    check("m1_err", err_count, 0);
    check("m1_flags", flags - fl0, 0);
    run(3, 0, c);
    check("m3_cycles", c, 18);
    check("m3_err", err_count, 0);
    r0 = rbad;
    for (int i = 0; i < 2; i++) begin
      fl0 = flags;
      run(2, 0, c);
      check("m2_done", c != 0, 1);
      check("m2_rd", rd_count, N);
      check("m2_err", err_count, 0);
      check("m2_enables", rbad - r0, 0);
      check("m2_flags", flags - fl0, 0);
    end
    flip_at = pops + 5;
    run(1, 0, c);
    check("flip_err", err_count, 1);
    check("flip_counts", {wr_count, rd_count}, {16'(N), 16'(N)});
    drop_at = pushes + 3; ov_at = pushes + 7;
    run(1, 0, c);
    check("ack_ovf_err", err_count, 2);
    check("ack_ovf_rd", rd_count, N);
    run(1, 6, c);
    check("restart_cycles", c, 18);
    check("restart_counts", {wr_count, rd_count}, {16'(N), 16'(N)});
    check("restart_err", err_count, 0);
    @(negedge clk); mode = 0; start = 1;
    @(negedge clk); start = 0;
    for (int k = 0; k < 100 && wr_count != 5; k++) @(negedge clk);
    check("abort_reach5", wr_count, 5);
    rst_n = 0;
    @(negedge clk); rst_n = 1;
    check("abort_busy", busy, 0);
    check("abort_counts", {wr_count, rd_count}, 0);
    check("abort_err", err_count, 0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_no_done", nd, 0);
    run(0, 0, c);
    check("post_cycles", c, 36);
    check("post_counts", {wr_count, rd_count}, {16'(N), 16'(N)});
    check("post_err", err_count, 0);
    check("data_in_seq", dbad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/fifo_traffic_gen.md
Name: fifo_traffic_gen

Overview:
Synthesizable stimulus master and self-checker for the synchronous FIFO. It drives the FIFO's write and read ports from an internal LFSR data pattern, honouring the full and empty flags. It also checks every sequential response: wr_ack, data_out, overflow and underflow. The block is instantiated opposite the FIFO in place of the bench driver, for on-chip and FPGA soak testing, and the existing passive monitor still observes the same interface.

Parameters:
FIFO_WIDTH, 16, data width; must match the FIFO.
NUM_TXN, 64, words written (and read) per run, 1..65535.
SEED, 16'hACE1, non-zero LFSR seed for the data and random-mode generators.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begins a run when idle
mode  in  2  0=fill/drain, 1=streaming, 2=random, 3=same as 1
full  in  1  from FIFO
empty  in  1  from FIFO
wr_ack  in  1  from FIFO (registered in FIFO)
overflow  in  1  from FIFO (registered)
underflow  in  1  from FIFO (registered)
data_out  in  FIFO_WIDTH  from FIFO (registered)
wr_en  out  1  to FIFO
rd_en  out  1  to FIFO
data_in  out  FIFO_WIDTH  to FIFO
busy  out  1  run in progress
done  out  1  one-cycle pulse at run end
wr_count  out  16  writes accepted this run
rd_count  out  16  reads checked this run
err_count  out  16  saturating error count

Behaviour:
- Reset, and the first clk edge with rst_n=0: state IDLE; busy=0, done=0, data_in=0, all counters 0; both LFSRs = SEED; pending flags cleared. wr_en and rd_en are 0 while rst_n=0. Reset mid-run aborts with no done pulse.
- Data generation: 16-bit Fibonacci LFSR with taps x^16+x^14+x^13+x^11+1.
  - data_in = tx_lfsr, zero-extended or truncated to FIFO_WIDTH; tx_lfsr advances on each issued write.
  - rx_lfsr is an identical copy that advances on each checked read.
  - A third LFSR, seeded with ~SEED, supplies random enables in mode 2.
- Enables are combinational from state and flags; there is no path from wr_en/rd_en back to full/empty.
  - wr_en = want_wr & ~full & (wr_count < NUM_TXN)
  - rd_en = want_rd & ~empty
- States:
  - IDLE: start=1 latches mode and goes to RUN; busy=1; counters and LFSRs reload. start while busy is ignored.
  - RUN, mode 0: want_wr=1 until full is seen, then want_rd=1 until empty is seen; this repeats. want_wr stays 0 once wr_count=NUM_TXN.
  - RUN, mode 1: want_wr=want_rd=1 every cycle; simultaneous read and write allowed.
  - RUN, mode 2: want_wr = rnd[0], want_rd = rnd[1], sampled each cycle.
  - RUN -> FLUSH when rd_count reaches NUM_TXN on an issued read.
  - FLUSH: 1 cycle to perform the last check, then done=1 for one cycle, busy=0, back to IDLE.
- Checking: response latency is exactly 1 cycle.
  - A write issued at edge N expects wr_ack=1 at N+1. A missing ack is 1 error.
  - A read issued at N expects data_out == rx_lfsr at N+1. A mismatch is 1 error.
  - overflow=1 or underflow=1 in any cycle while busy is 1 error each; the generator must never provoke them.
  - err_count saturates at 16'hFFFF.
- wr_count and rd_count increment on issued operations. Both are held after done until the next start.

Test Plan:
- FIFO depth 8, mode 0, NUM_TXN=16, start: 8 writes then full; 8 reads then empty; repeat once. done after the 16th read check; wr_count=rd_count=16, err_count=0, overflow and underflow never seen.
- Mode 1, NUM_TXN=64: after the first write, rd_en=1 every cycle with wr_en=1; done about 66 cycles after start, err_count=0.
- Mode 2, NUM_TXN=100, SEED=16'h0001: run completes with rd_count=100, err_count=0; the wr_en/rd_en sequence is identical on a rerun.
- Bench flips data_out bit 0 on the 5th read in mode 1: err_count=1 at done, all other counts normal.
- rst_n=0 for 1 cycle during a mode 0 run at wr_count=5: next cycle busy=0, counters=0, no done pulse. A new start runs to completion with err_count=0; the FIFO is also reset by the bench.
- start pulsed again while busy: ignored; the run finishes with unchanged counts.
